// File: rtl/ctr_sched_pkg.sv
// rtl/ctr_sched_pkg.sv - shared types for the retire pairing scheduler
// Purpose: FSM state encoding, instruction width and the issued-pair record.
// Ports: none (package).
package ctr_sched_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr_1;
        logic [INSTR_W-1:0] instr_2;
    } pair_t;

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - per-copy retired-instruction buffer
// Purpose: DEPTH x INSTR_W FIFO with synchronous clear; head is visible combinationally.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous clear (dominates push/pop)
//   push, din        write din at tail
//   pop              drop head
//   dout             current head word
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
module retire_fifo
    import ctr_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout,
    output logic [CNTW-1:0]    count,
    output logic               full,
    output logic               empty
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);

    // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/retire_pair_sched.sv
// rtl/retire_pair_sched.sv - pairs lockstep retirement streams in order
// Purpose: buffer each copy's retired words, release matched pairs FIFO-ordered,
//          stall a full side, flag desync when skew persists for TIMEOUT cycles.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   retire_k_i, instr_k_i           copy k retirement (k = 1, 2)
//   flush_i                         synchronous clear of buffers and error state
//   stall_k_o                       side k full, or in ERR
//   cmp_valid_o, cmp_instr_k_o      one-cycle pulse with the issued pair
//   desync_o, ovf_o                 sticky skew-timeout / dropped-retire flags
//   pair_cnt_o                      saturating count of issued pairs
module retire_pair_sched
    import ctr_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               retire_1_i,
    input  logic [INSTR_W-1:0] instr_1_i,
    input  logic               retire_2_i,
    input  logic [INSTR_W-1:0] instr_2_i,
    input  logic               flush_i,
    output logic               stall_1_o,
    output logic               stall_2_o,
    output logic               cmp_valid_o,
    output logic [INSTR_W-1:0] cmp_instr_1_o,
    output logic [INSTR_W-1:0] cmp_instr_2_o,
    output logic               desync_o,
    output logic               ovf_o,
    output logic [31:0]        pair_cnt_o
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    sched_state_e       state;
    logic [CW-1:0]      skew;
    logic [CW-1:0]      skew_next;
    pair_t              cmp_q;
    logic [CNTW-1:0]    count_1, count_2;
    logic               full_1, full_2, empty_1, empty_2;
    logic [INSTR_W-1:0] head_1, head_2;
    logic               run, pop, push_1, push_2;

    // Flush and ERR both freeze the buffers; flush additionally clears them.
    assign run    = (state == RUN) && !flush_i;
    assign pop    = run && !empty_1 && !empty_2;
    // A full side can still accept when its head leaves at the same edge.
    assign push_1 = run && retire_1_i && (!full_1 || pop);
    assign push_2 = run && retire_2_i && (!full_2 || pop);

    retire_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk(clk_i), .rst_n(rst_ni), .clr(flush_i),
        .push(push_1), .pop(pop), .din(instr_1_i), .dout(head_1),
        .count(count_1), .full(full_1), .empty(empty_1)
    );

    retire_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
        .clk(clk_i), .rst_n(rst_ni), .clr(flush_i),
        .push(push_2), .pop(pop), .din(instr_2_i), .dout(head_2),
        .count(count_2), .full(full_2), .empty(empty_2)
    );

    always_comb begin
        skew_next = skew;
        if (pop || (empty_1 && empty_2))
            skew_next = '0;
        else if ((empty_1 != empty_2) && (skew != TMAX))
            skew_next = skew + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RUN;
            skew        <= '0;
            cmp_valid_o <= 1'b0;
            cmp_q       <= '0;
            ovf_o       <= 1'b0;
            pair_cnt_o  <= '0;
        end else if (flush_i) begin
            state       <= RUN;
            skew        <= '0;
            cmp_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
            pair_cnt_o  <= '0;
        end else if (state == ERR) begin
            cmp_valid_o <= 1'b0;
        end else begin
            cmp_valid_o <= pop;
            if (pop) begin
                cmp_q <= '{instr_1: head_1, instr_2: head_2};
                if (pair_cnt_o != '1) pair_cnt_o <= pair_cnt_o + 32'd1;
            end
            if ((retire_1_i && full_1 && !pop) || (retire_2_i && full_2 && !pop))
                ovf_o <= 1'b1;
            skew <= skew_next;
            if (skew_next == TMAX) state <= ERR;
        end
    end

    assign cmp_instr_1_o = cmp_q.instr_1;
    assign cmp_instr_2_o = cmp_q.instr_2;
    assign desync_o      = (state == ERR);
    assign stall_1_o     = full_1 || (state == ERR);
    assign stall_2_o     = full_2 || (state == ERR);

endmodule

// File: tb/tb_retire_pair_sched.sv
// tb/tb_retire_pair_sched.sv - scoreboard bench for retire_pair_sched
module tb_retire_pair_sched;
    import ctr_sched_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r1 = 1'b0, r2 = 1'b0, flush = 1'b0;
    logic [31:0] i1 = '0, i2 = '0;
    logic        stall_1, stall_2, cmp_valid, desync, ovf;
    logic [31:0] cmp_1, cmp_2, pair_cnt;

    retire_pair_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .retire_1_i(r1), .instr_1_i(i1),
        .retire_2_i(r2), .instr_2_i(i2),
        .flush_i(flush),
        .stall_1_o(stall_1), .stall_2_o(stall_2),
        .cmp_valid_o(cmp_valid), .cmp_instr_1_o(cmp_1), .cmp_instr_2_o(cmp_2),
        .desync_o(desync), .ovf_o(ovf), .pair_cnt_o(pair_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: two plain queues plus the skew/error bookkeeping.
    logic [31:0] mq1[$];
    logic [31:0] mq2[$];
    pair_t       exp_q[$];
    bit          m_err = 0, m_ovf = 0, m_valid = 0;
    int          m_skew = 0;
    logic [31:0] m_pairs = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mq1.delete(); mq2.delete(); exp_q.delete();
        m_err = 0; m_ovf = 0; m_valid = 0; m_skew = 0; m_pairs = '0;
    endtask

    // Applies the rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int  n1, n2;
        bit  popped;
        pair_t p;
        if (!rst_n) begin model_reset(); return; end
        if (flush) begin
            mq1.delete(); mq2.delete();
            m_err = 0; m_ovf = 0; m_valid = 0; m_skew = 0; m_pairs = '0;
            return;
        end
        if (m_err) begin m_valid = 0; return; end
        n1 = mq1.size();
        n2 = mq2.size();
        popped = (n1 > 0) && (n2 > 0);
        if (popped) begin
            p.instr_1 = mq1.pop_front();
            p.instr_2 = mq2.pop_front();
            exp_q.push_back(p);
            if (m_pairs != 32'hFFFF_FFFF) m_pairs++;
        end
        m_valid = popped;
        if (r1) begin
            if (n1 < DEPTH || popped) mq1.push_back(i1); else m_ovf = 1;
        end
        if (r2) begin
            if (n2 < DEPTH || popped) mq2.push_back(i2); else m_ovf = 1;
        end
        if (popped || (n1 == 0 && n2 == 0)) m_skew = 0;
        else if (m_skew < TIMEOUT) m_skew++;
        if (m_skew == TIMEOUT) m_err = 1;
    endtask

    // Monitor: compares everything the DUT presents, popping the scoreboard on each pulse.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            chk("cmp_valid", {31'd0, cmp_valid}, {31'd0, m_valid});
            if (cmp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pair: got %h/%h expected none", cmp_1, cmp_2);
                end else begin
                    p = exp_q.pop_front();
                    chk("cmp_instr_1", cmp_1, p.instr_1);
                    chk("cmp_instr_2", cmp_2, p.instr_2);
                end
            end
            chk("stall_1", {31'd0, stall_1}, {31'd0, (mq1.size() == DEPTH) || m_err});
            chk("stall_2", {31'd0, stall_2}, {31'd0, (mq2.size() == DEPTH) || m_err});
            chk("desync", {31'd0, desync}, {31'd0, m_err});
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
            chk("pair_cnt", pair_cnt, m_pairs);
        end
    end

    task automatic step(input bit a, input logic [31:0] x, input bit b, input logic [31:0] y, input bit f);
        r1 = a; i1 = x; r2 = b; i2 = y; flush = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        r1 = 0; r2 = 0; flush = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int p1, p2;
        bit a, b;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous retire on empty buffers.
        step(1, 32'h13, 1, 32'h13, 0);
        idle(2);

        // Copy 2 lags copy 1 by three cycles.
        step(1, 32'h11, 0, 0, 0);
        step(1, 32'h22, 0, 0, 0);
        step(1, 32'h33, 0, 0, 0);
        step(0, 0, 1, 32'hAA, 0);
        step(0, 0, 1, 32'hBB, 0);
        step(0, 0, 1, 32'hCC, 0);
        idle(2);

        // Fill side 1, overflow, then drain one.
        for (int k = 0; k < 4; k++) step(1, 32'h100 + k, 0, 0, 0);
        chk("stall_1_full", {31'd0, stall_1}, 32'd1);
        step(1, 32'h1FF, 0, 0, 0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        step(0, 0, 1, 32'h200, 0);
        idle(1);
        chk("stall_1_drop", {31'd0, stall_1}, 32'd0);

        // Asynchronous reset with two entries buffered.
        step(0, 0, 0, 0, 1);
        step(1, 32'h300, 0, 0, 0);
        step(1, 32'h301, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pair_cnt", pair_cnt, 32'd0);
        chk("rst_stall_1", {31'd0, stall_1}, 32'd0);
        chk("rst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h400, 1, 32'h401, 0);
        idle(2);

        // Skew timeout into ERR, retires ignored there.
        step(1, 32'h500, 0, 0, 0);
        idle(TIMEOUT);
        chk("desync_set", {31'd0, desync}, 32'd1);
        chk("stall_2_err", {31'd0, stall_2}, 32'd1);
        step(1, 32'h501, 1, 32'h502, 0);
        step(0, 0, 1, 32'h503, 0);
        idle(2);

        // Flush out of ERR while copy 2 retires: that retire must vanish.
        step(0, 0, 1, 32'h600, 1);
        chk("flush_desync", {31'd0, desync}, 32'd0);
        step(1, 32'h601, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 32'h602, 0);
        idle(2);

        // Randomized phases with varying retire bias per side.
        for (int ph = 0; ph < 12; ph++) begin
            p1 = $urandom_range(10, 90);
            p2 = (ph == 5) ? 0 : $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                a = ($urandom_range(0, 99) < p1);
                b = ($urandom_range(0, 99) < p2);
                if (stall_1 && $urandom_range(0, 3) != 0) a = 0;
                if (stall_2 && $urandom_range(0, 3) != 0) b = 0;
                step(a, $urandom, b, $urandom, ($urandom_range(0, 199) == 0));
            end
            if (m_err) step(0, 0, 0, 0, 1);
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/retire_pair_sched.md
Name: retire_pair_sched

Overview:
- Pairs the retirement streams of the two lockstep core copies under relational verification.
- Each copy may retire at a different cycle. This block buffers each copy's retired instruction words and releases them strictly in order, as matched pairs, to the contract-observation checker.
- Stalls the leading copy when its buffer fills.
- Flags a desync when one copy retires and the other does not catch up within a bounded window.

Parameters:
- DEPTH, 4: entries per side buffer; power of two, ≥2.
- TIMEOUT, 64: maximum cycles one side may hold entries while the other side is empty.
- CW, $clog2(TIMEOUT+1): skew-counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- retire_1_i  in  1  copy 1 retires this cycle
- instr_1_i  in  32  copy 1 retired instruction word
- retire_2_i  in  1  copy 2 retires this cycle
- instr_2_i  in  32  copy 2 retired instruction word
- flush_i  in  1  synchronous clear of buffers and error state
- stall_1_o  out  1  hold copy 1 (its buffer is full, or ERR)
- stall_2_o  out  1  hold copy 2
- cmp_valid_o  out  1  one-cycle pulse: paired instructions valid, checker must sample
- cmp_instr_1_o  out  32  paired copy-1 instruction
- cmp_instr_2_o  out  32  paired copy-2 instruction
- desync_o  out  1  sticky: skew timeout reached
- ovf_o  out  1  sticky: retire arrived while its side was full and not popping
- pair_cnt_o  out  32  pairs issued since reset/flush; saturates at all-ones

Behaviour:
- Reset (async, rst_ni=0):
  - Both buffers empty; FSM=RUN; skew counter 0.
  - All outputs 0, except stall_k_o=0.
- FSM states:
  - RUN: normal operation.
  - ERR: entered when skew counter reaches TIMEOUT.
  - In ERR: no pushes, no pops; stall_1_o=stall_2_o=1; desync_o=1. ERR exits only via flush_i or reset.
- Push (RUN): at a clock edge with retire_k_i=1, instr_k_i is written to side-k tail if count_k<DEPTH, or if count_k==DEPTH and a pop occurs at the same edge.
- Overflow: a retire while full with no pop is dropped and sets ovf_o (sticky). The FSM stays in RUN.
- Pop (RUN): at any edge where count_1>0 and count_2>0, both heads are popped.
  - cmp_instr_1_o/cmp_instr_2_o are registered from the heads.
  - cmp_valid_o=1 for exactly the following cycle; otherwise it is 0.
  - cmp_instr_* hold their last values when not popping.
- Latency: a retire sampled at edge E with the partner already buffered gives cmp_valid_o high after E+1. Simultaneous retires on empty buffers also give cmp_valid_o high after E+1 (pop at E+1). No combinational bypass.
- Ordering: pairs are strictly FIFO per side; the n-th retire of copy 1 always pairs with the n-th retire of copy 2.
- stall_k_o is combinational: (count_k==DEPTH) || FSM==ERR.
- Skew counter (RUN):
  - Increments each cycle in which exactly one side is non-empty.
  - Clears when both sides are empty or a pop occurs.
  - Reaching TIMEOUT moves the FSM to ERR at that edge. The counter saturates.
- pair_cnt_o increments on each pop and saturates.
- flush_i=1 at an edge:
  - Empties both buffers; clears the skew counter, pair_cnt_o, desync_o and ovf_o; FSM←RUN.
  - cmp_valid_o is 0 next cycle.
  - flush_i has priority over a simultaneous retire or pop; that retire is dropped silently (no ovf).
- Pointers wrap modulo DEPTH. Counts use $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package ctr_sched_pkg holds:
  - sched_state_e {RUN, ERR}
  - INSTR_W=32
  - the pair struct {instr_1, instr_2}
- One sub-module: retire_fifo (DEPTH×32, push/pop/count/full/empty, sync clear), instantiated once per side.

Test Plan:
- Retire both copies at the same edge with 0x00000013/0x00000013 → cmp_valid_o one cycle later, instrs match, pair_cnt_o=1.
- Copy 1 retires A, B, C (0x11, 0x22, 0x33) on consecutive cycles; copy 2 retires X, Y, Z three cycles later → pairs (A,X), (B,Y), (C,Z) in order, one pulse each.
- Copy 1 retires 4 times with copy 2 idle (DEPTH=4) → stall_1_o=1 after the 4th. A 5th retire sets ovf_o=1 and is dropped. Copy 2 then retires once → pair issued and stall_1_o drops.
- Copy 1 retires once, copy 2 silent for 64 cycles → desync_o=1, both stalls=1. Further retires on both sides produce no cmp_valid_o.
- In ERR, assert flush_i together with retire_2_i → next cycle all counts 0, desync_o=0, ovf_o=0, pair_cnt_o=0, and the retire is not buffered.
- Reset asserted mid-stream (two entries buffered) → outputs 0 immediately; after release, new retires pair from an empty state.
